loop_fetch_ctrl: RTL and testbench
==================================

LOOP_FETCH_CTRL -- requirements
Module: loop_fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: width of all PC/target buses.
REQ-002 SHALL have parameter BTB_ENTRIES, default 8, power of two: branch-target-buffer depth.
REQ-003 SHALL have parameter TRK_DEPTH, default 4, power of two: in-flight prediction tracking FIFO depth.
REQ-004 SHALL have port cpu_clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port cpu_rst  in  1  reset; asynchronous, active-high.
REQ-006 SHALL have port pc  in  ADDR_WIDTH  current fetch PC.
REQ-007 SHALL have port fetch_valid  in  1  IF presents an instruction at pc.
REQ-008 SHALL have port is_loop  in  1  loop-predictor hit for pc.
REQ-009 SHALL have port loop_predict_taken  in  1  loop-predictor taken prediction for pc.
REQ-010 SHALL have port ex_valid  in  1  an instruction retires from EX this cycle.
REQ-011 SHALL have port ex_branch  in  1  the retiring instruction is a branch.
REQ-012 SHALL have port ex_taken  in  1  resolved branch direction.
REQ-013 SHALL have port ex_pc  in  ADDR_WIDTH  PC of the retiring instruction.
REQ-014 SHALL have port ex_target  in  ADDR_WIDTH  resolved branch target.
REQ-015 SHALL have port fetch_ready  out  1  fetch accepted (tracking FIFO not full).
REQ-016 SHALL have port next_pc  out  ADDR_WIDTH  next fetch address.
REQ-017 SHALL have port flush  out  1  one-cycle mispredict flush pulse.
REQ-018 SHALL have port mispredict_cnt  out  16  saturating mispredict count.
REQ-019 SHALL have port trk_err  out  1  sticky error: ex_valid seen while FIFO empty.

Function
REQ-020 SHALL hold a BTB: index pc[log2(BTB_ENTRIES)+1:2], tag the remaining upper bits, a valid bit, and a target.
REQ-021 SHALL compute btb_hit combinationally as (entry valid & tag match) for pc.
REQ-022 SHALL set pred_taken = is_loop & loop_predict_taken & btb_hit.
REQ-023 SHALL drive next_pc combinationally: flush ? redirect_pc : pred_taken ? BTB target : pc+4, with modulo-2^ADDR_WIDTH wrap.
REQ-024 SHALL write the BTB entry (valid=1, tag, ex_target) on ex_valid & ex_branch & ex_taken & ~trk_empty; same-cycle read returns the old content, new content visible the next cycle.
REQ-025 SHALL drive fetch_ready = ~full & ~flush.
REQ-026 SHALL push {pc, pred_taken, predicted next_pc} into the tracking FIFO on fetch_valid & fetch_ready.
REQ-027 SHALL pop one entry on ex_valid when the FIFO is not empty; simultaneous push and pop leave the occupancy unchanged, and a push is allowed when full only if a pop occurs in the same cycle.
REQ-028 SHALL detect a mispredict on a pop when: (ex_branch & ex_taken) != pred_taken, or pred_taken & ex_taken & ex_target != stored target, or stored pc != ex_pc.
REQ-029 SHALL assert flush for exactly one cycle, at the edge after detection, with redirect_pc registered as ex_taken&ex_branch ? ex_target : ex_pc+4.
REQ-030 SHALL, on that same edge, empty the FIFO (pointers and count to 0) and discard any same-cycle push.
REQ-031 SHALL ignore ex_valid while the FIFO is empty: no pop, no flush, no BTB write, and trk_err is set until reset.
REQ-032 SHALL increment mispredict_cnt by 1 per detection and saturate at 16'hFFFF.
REQ-033 SHALL, if ex_valid coincides with a flush cycle, treat it as wrong-path: no pop and no detection.

Reset
REQ-034 SHALL, while cpu_rst is high, asynchronously clear: all BTB valid bits, FIFO pointers/count, flush, redirect_pc, mispredict_cnt, and trk_err, all to 0.
REQ-035 SHALL have fetch_ready=1 and next_pc=pc+4 during and immediately after reset.
REQ-036 SHALL, when reset is asserted mid-operation, drop in-flight entries without generating a flush pulse.

Verification
REQ-037 SHALL pass: after reset, pc=0x100, fetch_valid=1, is_loop=1, taken=1 -> next_pc=0x104 (BTB miss), FIFO count=1.
REQ-038 SHALL pass: resolve branch 0x100 taken to 0x80 -> next cycle pc=0x100 with is_loop&taken gives next_pc=0x80.
REQ-039 SHALL pass: 4 fetches with no ex_valid -> fetch_ready=0; a 5th fetch together with ex_valid is accepted and count stays 4.
REQ-040 SHALL pass: predicted-taken 0x100 resolves not-taken -> flush=1 for one cycle, next_pc=0x104, count=0, mispredict_cnt=1.
REQ-041 SHALL pass: ex_valid with empty FIFO -> trk_err=1 and stays 1; no flush and no BTB change.
REQ-042 SHALL pass: 65536 forced mispredicts -> mispredict_cnt=16'hFFFF, unchanged after the next mispredict.

Source files
------------

// File: rtl/loop_fetch_ctrl.sv
// Next-PC selection from a loop predictor gated by a small BTB, with a FIFO of in-flight predictions checked at retire.
// next_pc is combinational from pc; flush pulses one cycle after a retire-time mismatch is seen.
// fetch_ready drops while the tracking FIFO is full (unless a retire frees a slot that cycle) and during flush.
module loop_fetch_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int BTB_ENTRIES = 8,
    parameter int TRK_DEPTH   = 4
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  fetch_valid,
    input  logic                  is_loop,
    input  logic                  loop_predict_taken,
    input  logic                  ex_valid,
    input  logic                  ex_branch,
    input  logic                  ex_taken,
    input  logic [ADDR_WIDTH-1:0] ex_pc,
    input  logic [ADDR_WIDTH-1:0] ex_target,
    output logic                  fetch_ready,
    output logic [ADDR_WIDTH-1:0] next_pc,
    output logic                  flush,
    output logic [15:0]           mispredict_cnt,
    output logic                  trk_err
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;
    localparam int PTR_W = $clog2(TRK_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic                  pred;
        logic [ADDR_WIDTH-1:0] npc;
    } trk_ent_t;

    logic [BTB_ENTRIES-1:0] btb_vld;
    logic [TAG_W-1:0]       btb_tag [BTB_ENTRIES];
    logic [ADDR_WIDTH-1:0]  btb_tgt [BTB_ENTRIES];

    trk_ent_t               trk_mem [TRK_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       trk_cnt;
    logic [ADDR_WIDTH-1:0]  redirect_pc;

    logic [IDX_W-1:0]       fetch_idx;
    logic [IDX_W-1:0]       ex_idx;
    logic [TAG_W-1:0]       fetch_tag;
    logic [TAG_W-1:0]       ex_tag;
    logic [ADDR_WIDTH-1:0]  pc_inc;
    logic                   btb_hit;
    logic                   pred_taken;
    logic                   trk_full;
    logic                   trk_empty;
    logic                   push;
    logic                   pop;
    logic                   miss;
    logic                   btb_we;
    trk_ent_t               head;

    assign fetch_idx = pc[IDX_W+1:2];
    assign fetch_tag = pc[ADDR_WIDTH-1:IDX_W+2];
    assign ex_idx    = ex_pc[IDX_W+1:2];
    assign ex_tag    = ex_pc[ADDR_WIDTH-1:IDX_W+2];

    assign btb_hit    = btb_vld[fetch_idx] & (btb_tag[fetch_idx] == fetch_tag);
    assign pred_taken = is_loop & loop_predict_taken & btb_hit;
    assign pc_inc     = pc + ADDR_WIDTH'(4);
    assign next_pc    = flush ? redirect_pc : (pred_taken ? btb_tgt[fetch_idx] : pc_inc);

    // Retires landing in the flush cycle are wrong-path and never pop.
    assign trk_full    = (trk_cnt == CNT_W'(TRK_DEPTH));
    assign trk_empty   = (trk_cnt == '0);
    assign pop         = ex_valid & ~trk_empty & ~flush;
    assign fetch_ready = ~flush & (~trk_full | pop);
    assign push        = fetch_valid & fetch_ready;
    assign head        = trk_mem[rd_ptr];

    assign miss = pop & (((ex_branch & ex_taken) != head.pred)
                       | (head.pred & ex_taken & (ex_target != head.npc))
                       | (head.pc != ex_pc));
    assign btb_we = pop & ex_branch & ex_taken;

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            btb_vld <= '0;
        end else if (btb_we) begin
            btb_vld[ex_idx] <= 1'b1;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (btb_we) begin
            btb_tag[ex_idx] <= ex_tag;
            btb_tgt[ex_idx] <= ex_target;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (push & ~miss) begin
            trk_mem[wr_ptr] <= '{pc: pc, pred: pred_taken, npc: next_pc};
        end
    end

    // A mismatch squashes everything younger, including a push in the same cycle.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            trk_cnt <= '0;
        end else if (miss) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            trk_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push & ~pop)      trk_cnt <= trk_cnt + CNT_W'(1);
            else if (pop & ~push) trk_cnt <= trk_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            flush          <= 1'b0;
            redirect_pc    <= '0;
            mispredict_cnt <= '0;
            trk_err        <= 1'b0;
        end else begin
            flush <= miss;
            if (miss) begin
                redirect_pc <= (ex_branch & ex_taken) ? ex_target : ex_pc + ADDR_WIDTH'(4);
                if (mispredict_cnt != 16'hFFFF) mispredict_cnt <= mispredict_cnt + 16'd1;
            end
            if (ex_valid & trk_empty & ~flush) trk_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_loop_fetch_ctrl.sv
// Directed bench for loop_fetch_ctrl: BTB learn/hit, FIFO backpressure, mispredict flush, empty-retire error, saturation, reset.
module tb_loop_fetch_ctrl;
    logic        cpu_clk;
    logic        cpu_rst;
    logic [31:0] pc;
    logic        fetch_valid;
    logic        is_loop;
    logic        loop_predict_taken;
    logic        ex_valid;
    logic        ex_branch;
    logic        ex_taken;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        fetch_ready;
    logic [31:0] next_pc;
    logic        flush;
    logic [15:0] mispredict_cnt;
    logic        trk_err;

    int errors = 0;
    int checks = 0;

    loop_fetch_ctrl #(.ADDR_WIDTH(32), .BTB_ENTRIES(8), .TRK_DEPTH(4)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .pc(pc), .fetch_valid(fetch_valid),
        .is_loop(is_loop), .loop_predict_taken(loop_predict_taken),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_taken(ex_taken),
        .ex_pc(ex_pc), .ex_target(ex_target), .fetch_ready(fetch_ready),
        .next_pc(next_pc), .flush(flush), .mispredict_cnt(mispredict_cnt), .trk_err(trk_err)
    );

    initial begin
        cpu_clk = 1'b0;
        forever #5 cpu_clk = ~cpu_clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    // One forced mispredict: push pc 0x300, retire it under a different PC, then sit through the flush.
    task automatic force_miss();
        fetch_valid = 1'b1; pc = 32'h300; is_loop = 1'b0; ex_valid = 1'b0;
        tick();
        fetch_valid = 1'b0; ex_valid = 1'b1; ex_branch = 1'b0; ex_taken = 1'b0; ex_pc = 32'h308;
        tick();
        ex_valid = 1'b0;
        tick();
    endtask

    initial begin
        cpu_rst = 1'b1; pc = 32'h100; fetch_valid = 1'b0; is_loop = 1'b0; loop_predict_taken = 1'b0;
        ex_valid = 1'b0; ex_branch = 1'b0; ex_taken = 1'b0; ex_pc = '0; ex_target = '0;
        #2;
        chk("rst_ready", {31'd0, fetch_ready}, 32'd1);
        chk("rst_next_pc", next_pc, 32'h104);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_mcnt", {16'd0, mispredict_cnt}, 32'd0);
        chk("rst_err", {31'd0, trk_err}, 32'd0);
        tick();
        cpu_rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, fetch_ready}, 32'd1);
        chk("post_rst_next_pc", next_pc, 32'h104);

        // Cold BTB: loop predictor says taken but the BTB misses.
        fetch_valid = 1'b1; is_loop = 1'b1; loop_predict_taken = 1'b1; pc = 32'h100;
        #1;
        chk("cold_next_pc", next_pc, 32'h104);
        tick();
        fetch_valid = 1'b0;
        #1;
        chk("cold_fifo_cnt", {29'd0, dut.trk_cnt}, 32'd1);

        // Branch 0x100 resolves taken to 0x80: mismatch with the not-taken prediction, BTB learns.
        ex_valid = 1'b1; ex_branch = 1'b1; ex_taken = 1'b1; ex_pc = 32'h100; ex_target = 32'h80;
        tick();
        ex_valid = 1'b0;
        #1;
        chk("learn_flush", {31'd0, flush}, 32'd1);
        chk("learn_redirect", next_pc, 32'h80);
        chk("learn_ready_low", {31'd0, fetch_ready}, 32'd0);
        chk("learn_mcnt", {16'd0, mispredict_cnt}, 32'd1);
        chk("learn_fifo_cnt", {29'd0, dut.trk_cnt}, 32'd0);
        tick();
        chk("learn_flush_end", {31'd0, flush}, 32'd0);
        chk("btb_hit_next_pc", next_pc, 32'h80);
        is_loop = 1'b0;
        #1;
        chk("btb_hit_no_loop", next_pc, 32'h104);

        // Fill the FIFO, then a fifth fetch rides on a simultaneous retire.
        for (int i = 0; i < 4; i++) begin
            pc = 32'h200 + 32'(4 * i); fetch_valid = 1'b1;
            tick();
        end
        pc = 32'h210;
        #1;
        chk("full_ready_low", {31'd0, fetch_ready}, 32'd0);
        chk("full_fifo_cnt", {29'd0, dut.trk_cnt}, 32'd4);
        ex_valid = 1'b1; ex_branch = 1'b0; ex_taken = 1'b0; ex_pc = 32'h200;
        #1;
        chk("full_pop_ready", {31'd0, fetch_ready}, 32'd1);
        tick();
        fetch_valid = 1'b0; ex_valid = 1'b0;
        #1;
        chk("full_pushpop_cnt", {29'd0, dut.trk_cnt}, 32'd4);
        chk("full_no_flush", {31'd0, flush}, 32'd0);

        for (int i = 0; i < 4; i++) begin
            ex_valid = 1'b1; ex_pc = 32'h204 + 32'(4 * i);
            tick();
        end
        ex_valid = 1'b0;
        #1;
        chk("drain_cnt", {29'd0, dut.trk_cnt}, 32'd0);
        chk("drain_mcnt", {16'd0, mispredict_cnt}, 32'd1);

        // Predicted-taken 0x100 resolves not-taken; a same-cycle push must be discarded.
        pc = 32'h100; is_loop = 1'b1; loop_predict_taken = 1'b1; fetch_valid = 1'b1;
        #1;
        chk("pred_next_pc", next_pc, 32'h80);
        tick();
        pc = 32'h80; is_loop = 1'b0;
        ex_valid = 1'b1; ex_branch = 1'b1; ex_taken = 1'b0; ex_pc = 32'h100; ex_target = 32'h80;
        tick();
        fetch_valid = 1'b0; ex_valid = 1'b0;
        #1;
        chk("nt_flush", {31'd0, flush}, 32'd1);
        chk("nt_redirect", next_pc, 32'h104);
        chk("nt_fifo_cnt", {29'd0, dut.trk_cnt}, 32'd0);
        chk("nt_mcnt", {16'd0, mispredict_cnt}, 32'd2);
        tick();
        chk("nt_flush_one_cycle", {31'd0, flush}, 32'd0);
        chk("nt_after_next_pc", next_pc, 32'h84);

        // Retire with an empty FIFO: sticky error, no flush, no BTB write.
        pc = 32'h200; is_loop = 1'b1; loop_predict_taken = 1'b1;
        ex_valid = 1'b1; ex_branch = 1'b1; ex_taken = 1'b1; ex_pc = 32'h200; ex_target = 32'h300;
        tick();
        ex_valid = 1'b0;
        #1;
        chk("empty_err", {31'd0, trk_err}, 32'd1);
        chk("empty_no_flush", {31'd0, flush}, 32'd0);
        chk("empty_no_btb_write", next_pc, 32'h204);
        tick();
        chk("empty_err_sticky", {31'd0, trk_err}, 32'd1);

        // Saturation: count is 2 here, 65532 more reach 0xFFFE.
        for (int i = 0; i < 65532; i++) force_miss();
        chk("sat_fffe", {16'd0, mispredict_cnt}, 32'hFFFE);
        force_miss();
        chk("sat_ffff", {16'd0, mispredict_cnt}, 32'hFFFF);
        for (int i = 0; i < 4; i++) force_miss();
        chk("sat_hold", {16'd0, mispredict_cnt}, 32'hFFFF);

        // Reset while a mismatch is pending must not produce a flush.
        fetch_valid = 1'b1; pc = 32'h300; is_loop = 1'b0;
        tick();
        fetch_valid = 1'b0; ex_valid = 1'b1; ex_branch = 1'b0; ex_taken = 1'b0; ex_pc = 32'h308;
        #1;
        cpu_rst = 1'b1;
        #1;
        chk("mid_rst_flush", {31'd0, flush}, 32'd0);
        chk("mid_rst_mcnt", {16'd0, mispredict_cnt}, 32'd0);
        chk("mid_rst_err", {31'd0, trk_err}, 32'd0);
        chk("mid_rst_fifo", {29'd0, dut.trk_cnt}, 32'd0);
        tick();
        chk("mid_rst_edge_flush", {31'd0, flush}, 32'd0);
        ex_valid = 1'b0; pc = 32'h100; is_loop = 1'b1; loop_predict_taken = 1'b1;
        #1;
        chk("mid_rst_btb_clear", next_pc, 32'h104);
        chk("mid_rst_ready", {31'd0, fetch_ready}, 32'd1);
        cpu_rst = 1'b0;
        tick();
        chk("post_mid_rst_flush", {31'd0, flush}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
